// File: rtl/mbist_march_if.sv
// mbist_march_if: bundles the MBIST controller's memory-side and status signals.
interface mbist_march_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                  start;
    logic                  write_read;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [CNT_WIDTH-1:0]  fail_count;
    logic [ADDR_WIDTH-1:0] first_fail_addr;
    logic [2:0]            first_fail_elem;
    modport master (
        input  start, rdata,
        output write_read, address, wdata, busy, done, pass,
               fail_count, first_fail_addr, first_fail_elem
    );
    modport slave (
        output start, rdata,
        input  write_read, address, wdata, busy, done, pass,
               fail_count, first_fail_addr, first_fail_elem
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory BIST sequencer with a 2-cycle read-compare pipe,
// saturating miscompare counter and first-failure capture.
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LAST_ADDR  = 15,
    parameter int CNT_WIDTH  = 16
) (
    input logic           clk,
    input logic           rst,
    mbist_march_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] exp;
        logic [2:0]            elem;
        logic [ADDR_WIDTH-1:0] addr;
    } tag_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d, ffe_q, ffe_d, nxt_elem;
    logic                  op_q, op_d, drain_q, drain_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, ffa_q, ffa_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;
    tag_t                  p1_q, p1_d, p2_q, p2_d;
    logic                  two_op, down, wr, last_op, at_end, miscmp;
    always_comb begin
        two_op   = elem_q != 3'd0 && elem_q != 3'd5;
        down     = elem_q == 3'd3 || elem_q == 3'd4;
        nxt_elem = elem_q + 3'd1;
        wr       = state_q == RUN && (elem_q == 3'd0 || (two_op && op_q));
        last_op  = !two_op || op_q;
        at_end   = addr_q == (down ? '0 : LAST);
        miscmp   = p2_q.valid && bus.rdata != p2_q.exp;
        state_d  = state_q;
        elem_d   = elem_q;
        op_d     = op_q;
        drain_d  = drain_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        // Reads only carry a valid tag in RUN; SETUP and DRAIN reads are fillers.
        p1_d.valid = state_q == RUN && !wr;
        p1_d.exp   = {DATA_WIDTH{elem_q == 3'd2 || elem_q == 3'd4}};
        p1_d.elem  = elem_q;
        p1_d.addr  = addr_q;
        p2_d       = p1_q;
        fail_count_d = miscmp && !(&fail_count_q) ? fail_count_q + 1'b1 : fail_count_q;
        ffa_d        = miscmp && fail_count_q == '0 ? p2_q.addr : ffa_q;
        ffe_d        = miscmp && fail_count_q == '0 ? p2_q.elem : ffe_q;
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                state_d      = SETUP;
                elem_d       = 3'd0;
                op_d         = 1'b0;
                addr_d       = '0;
                wdata_d      = '0;
                fail_count_d = '0;
                ffa_d        = '0;
                ffe_d        = 3'd0;
            end
            SETUP: state_d = RUN;
            RUN: begin
                op_d = !last_op;
                if (last_op && !at_end)
                    addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
                else if (last_op && elem_q == 3'd5) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else if (last_op) begin
                    state_d = SETUP;
                    elem_d  = nxt_elem;
                    addr_d  = (nxt_elem == 3'd3 || nxt_elem == 3'd4) ? LAST : '0;
                    wdata_d = {DATA_WIDTH{nxt_elem == 3'd1 || nxt_elem == 3'd3}};
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                state_d = drain_q ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            elem_q       <= 3'd0;
            op_q         <= 1'b0;
            drain_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fail_count_q <= '0;
            ffa_q        <= '0;
            ffe_q        <= 3'd0;
            p1_q         <= '0;
            p2_q         <= '0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            op_q         <= op_d;
            drain_q      <= drain_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            fail_count_q <= fail_count_d;
            ffa_q        <= ffa_d;
            ffe_q        <= ffe_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
        end
    end
    assign bus.write_read      = wr;
    assign bus.address         = addr_q;
    assign bus.wdata           = wdata_q;
    assign bus.busy            = state_q inside {SETUP, RUN, DRAIN};
    assign bus.done            = state_q == DONE;
    assign bus.pass            = state_q == DONE && fail_count_q == '0;
    assign bus.fail_count      = fail_count_q;
    assign bus.first_fail_addr = ffa_q;
    assign bus.first_fail_elem = ffe_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: drives the March C- controller against a stuck-at memory model
// and checks results and the op trace against a march-algorithm reference.
module tb_mbist_march_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mbist_march_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(16)) bus();
    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LAST_ADDR(15), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct packed {logic wr; logic [3:0] a; logic [7:0] d; logic care;} tr_t;
    logic [7:0] mem [16];
    logic [7:0] sa0 [16];
    logic [7:0] sa1 [16];
    logic [7:0] wd_q, r1;
    tr_t cap[$];
    tr_t exp_tr[$];
    int checks = 0, passes = 0, fails = 0;
    int busy_cycles, hold_err;
    bit up_t [6] = '{1, 1, 1, 0, 0, 1};
    bit rd_t [6] = '{0, 1, 1, 1, 1, 1};
    bit wr_t [6] = '{1, 1, 1, 1, 1, 0};
    bit wv_t [6] = '{0, 1, 0, 1, 0, 0};
    bit rv_t [6] = '{0, 0, 1, 0, 1, 0};

    // Memory: wdata registered once, read data two cycles after the address edge.
    always @(posedge clk) begin
        wd_q <= bus.wdata;
        if (bus.write_read) mem[bus.address] <= wd_q;
        r1 <= (mem[bus.address] & ~sa0[bus.address]) | sa1[bus.address];
        bus.rdata <= r1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 16; i++) begin
            sa0[i] = 8'h00;
            sa1[i] = 8'h00;
        end
    endtask

    function automatic void march_ref(output int cnt, output int fa, output int fe);
        logic [7:0] m [16];
        logic [7:0] v;
        cnt = 0; fa = 0; fe = 0;
        for (int i = 0; i < 16; i++) m[i] = 8'($urandom);
        for (int e = 0; e < 6; e++)
            for (int k = 0; k < 16; k++) begin
                int a = up_t[e] ? k : 15 - k;
                if (rd_t[e]) begin
                    v = (m[a] & ~sa0[a]) | sa1[a];
                    if (v != {8{rv_t[e]}}) begin
                        if (cnt == 0) begin fa = a; fe = e; end
                        cnt++;
                    end
                end
                if (wr_t[e]) m[a] = {8{wv_t[e]}};
            end
    endfunction

    task automatic build_exp();
        exp_tr.delete();
        for (int e = 0; e < 6; e++) begin
            exp_tr.push_back('{1'b0, up_t[e] ? 4'd0 : 4'd15, {8{wv_t[e]}}, 1'b1});
            for (int k = 0; k < 16; k++) begin
                logic [3:0] a = up_t[e] ? 4'(k) : 4'(15 - k);
                if (rd_t[e]) exp_tr.push_back('{1'b0, a, {8{wv_t[e]}}, 1'b1});
                if (wr_t[e]) exp_tr.push_back('{1'b1, a, {8{wv_t[e]}}, 1'b1});
            end
        end
        repeat (2) exp_tr.push_back('{1'b0, 4'd0, 8'h00, 1'b0});
    endtask

    task automatic run_test(input int glitch);
        logic [7:0] prev;
        cap.delete();
        hold_err = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_busy", bus.busy, 1);
        check("start_clr_done", bus.done, 0);
        check("start_clr_count", bus.fail_count, 0);
        busy_cycles = 0;
        prev = bus.wdata;
        while (bus.busy && busy_cycles < 400) begin
            busy_cycles++;
            bus.start = busy_cycles == glitch;
            cap.push_back('{bus.write_read, bus.address, bus.wdata, 1'b1});
            if (bus.write_read && bus.wdata !== prev) hold_err++;
            prev = bus.wdata;
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic verify(input string tag);
        int cnt, fa, fe, bad;
        march_ref(cnt, fa, fe);
        check({tag, "_busy_cycles"}, busy_cycles, 168);
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_fail_count"}, bus.fail_count, cnt);
        check({tag, "_pass"}, bus.pass, cnt == 0);
        check({tag, "_ff_addr"}, bus.first_fail_addr, fa);
        check({tag, "_ff_elem"}, bus.first_fail_elem, fe);
        check({tag, "_wdata_hold"}, hold_err, 0);
        check({tag, "_trace_len"}, cap.size(), exp_tr.size());
        bad = 0;
        for (int i = 0; i < cap.size() && i < exp_tr.size(); i++)
            if (cap[i].wr !== exp_tr[i].wr || cap[i].d !== exp_tr[i].d ||
                (exp_tr[i].care && cap[i].a !== exp_tr[i].a)) bad++;
        check({tag, "_trace"}, bad, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr"}, bus.write_read, 0);
        check({tag, "_addr"}, bus.address, 0);
        check({tag, "_wdata"}, bus.wdata, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_pass"}, bus.pass, 0);
        check({tag, "_count"}, bus.fail_count, 0);
        check({tag, "_ffa"}, bus.first_fail_addr, 0);
        check({tag, "_ffe"}, bus.first_fail_elem, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        clear_faults();
        build_exp();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        run_test(0);
        verify("clean");
        sa0[9] = 8'h08;
        run_test(50);
        verify("addr9_sa0_glitch");
        clear_faults();
        sa1[0] = 8'h80;
        run_test(0);
        verify("addr0_sa1");
        for (int it = 0; it < 6; it++) begin
            clear_faults();
            for (int f = $urandom_range(0, 3); f > 0; f--) begin
                int a = $urandom_range(0, 15);
                logic [7:0] m = 8'(1 << $urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) sa1[a] = sa1[a] | m;
                else sa0[a] = sa0[a] | m;
            end
            run_test(0);
            verify($sformatf("rand%0d", it));
        end
        for (int i = 0; i < 16; i++) sa1[i] = 8'h01;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (94) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        check("post_abort_count", bus.fail_count, 0);
        check("post_abort_busy", bus.busy, 0);
        run_test(0);
        verify("after_abort");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
